// File: rtl/auth_request_arbiter.sv
// Request stage ahead of authentication_driver: one holding register per source (PD, DEBUG),
// round-robin issue of an encoded request byte, and a watchdog on the acknowledge/done waits.
module auth_request_arbiter #(
   parameter int TIMEOUT_W = 8,
   parameter int TIMEOUT   = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pd_req_valid,
   input  logic [1:0] pd_req_role,
   input  logic       pd_req_usb,
   output logic       pd_req_accept,
   input  logic       debug_req_valid,
   input  logic [1:0] debug_req_role,
   input  logic       debug_req_usb,
   output logic       debug_req_accept,
   output logic [1:0] req_reject,
   input  logic       PD_in_ready,
   input  logic       DEBUG_in_ready,
   input  logic       auth_msg_ready,
   output logic [7:0] pending_auth_request,
   output logic       busy,
   output logic       timeout_err
);

   typedef enum logic [3:0] {
      ST_IDLE      = 4'b0001,
      ST_ISSUE     = 4'b0010,
      ST_WAIT_DONE = 4'b0100,
      ST_RELEASE   = 4'b1000
   } state_t;

   localparam logic [TIMEOUT_W-1:0] WD_LIMIT = TIMEOUT_W'(TIMEOUT - 1);

   // Index 0 is PD, index 1 is DEBUG throughout.
   logic [1:0] req_valid_vec;
   logic [1:0] req_usb_vec;
   logic [1:0] req_role_arr [2];
   logic [1:0] in_ready_vec;
   logic [1:0] hold_valid_vec;
   logic [1:0] accept_vec;
   logic [1:0] reject_vec;
   logic [1:0] free_vec;
   logic [7:0] enc_arr [2];

   state_t               state_reg;
   logic                 rr_reg;
   logic                 win_reg;
   logic [TIMEOUT_W-1:0] wd_reg;
   logic [7:0]           pending_reg;
   logic                 timeout_reg;

   logic win_next;
   logic waiting;
   logic exit_now;
   logic wd_expired;
   logic abort;

   assign req_valid_vec   = {debug_req_valid, pd_req_valid};
   assign req_usb_vec     = {debug_req_usb, pd_req_usb};
   assign req_role_arr[0] = pd_req_role;
   assign req_role_arr[1] = debug_req_role;
   assign in_ready_vec    = {DEBUG_in_ready, PD_in_ready};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         localparam logic [1:0] REQ_ID = (gi == 0) ? 2'b01 : 2'b10;

         logic       hold_valid_reg;
         logic [1:0] hold_role_reg;
         logic       hold_usb_reg;
         logic       accept_reg;
         logic       reject_reg;
         logic       role_legal;

         assign role_legal = (req_role_arr[gi] == 2'b01) || (req_role_arr[gi] == 2'b10);

         // A full register ignores the requester; freeing and capturing never share an edge.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               hold_valid_reg <= 1'b0;
               hold_role_reg  <= 2'b00;
               hold_usb_reg   <= 1'b0;
               accept_reg     <= 1'b0;
               reject_reg     <= 1'b0;
            end else begin
               accept_reg <= 1'b0;
               reject_reg <= 1'b0;
               if (hold_valid_reg) begin
                  if (free_vec[gi]) begin
                     hold_valid_reg <= 1'b0;
                  end
               end else if (req_valid_vec[gi]) begin
                  if (role_legal) begin
                     hold_valid_reg <= 1'b1;
                     hold_role_reg  <= req_role_arr[gi];
                     hold_usb_reg   <= req_usb_vec[gi];
                     accept_reg     <= 1'b1;
                  end else begin
                     reject_reg <= 1'b1;
                  end
               end
            end
         end

         assign hold_valid_vec[gi] = hold_valid_reg;
         assign accept_vec[gi]     = accept_reg;
         assign reject_vec[gi]     = reject_reg;
         assign enc_arr[gi]        = {REQ_ID, hold_role_reg, 1'b0, hold_usb_reg, 2'b00};
      end
   endgenerate

   // rr only breaks ties; a lone valid source wins regardless of the pointer.
   assign win_next   = (hold_valid_vec == 2'b11) ? rr_reg : hold_valid_vec[1];
   assign waiting    = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT_DONE);
   assign exit_now   = ((state_reg == ST_ISSUE) && in_ready_vec[win_reg]) ||
                       ((state_reg == ST_WAIT_DONE) && auth_msg_ready);
   assign wd_expired = (wd_reg == WD_LIMIT);
   assign abort      = waiting && wd_expired && !exit_now;

   always_comb begin
      free_vec = 2'b00;
      if ((state_reg == ST_RELEASE) || abort) begin
         free_vec[win_reg] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         rr_reg      <= 1'b0;
         win_reg     <= 1'b0;
         wd_reg      <= '0;
         pending_reg <= 8'h00;
         timeout_reg <= 1'b0;
      end else begin
         timeout_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (|hold_valid_vec) begin
                  win_reg     <= win_next;
                  pending_reg <= enc_arr[win_next];
                  wd_reg      <= '0;
                  state_reg   <= ST_ISSUE;
               end
            end
            ST_ISSUE, ST_WAIT_DONE: begin
               if (exit_now) begin
                  wd_reg <= '0;
                  if (state_reg == ST_ISSUE) begin
                     pending_reg <= 8'h00;
                     state_reg   <= ST_WAIT_DONE;
                  end else begin
                     state_reg <= ST_RELEASE;
                  end
               end else if (wd_expired) begin
                  pending_reg <= 8'h00;
                  timeout_reg <= 1'b1;
                  wd_reg      <= '0;
                  rr_reg      <= ~rr_reg;
                  state_reg   <= ST_IDLE;
               end else begin
                  wd_reg <= wd_reg + 1'b1;
               end
            end
            ST_RELEASE: begin
               rr_reg    <= ~rr_reg;
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign pd_req_accept        = accept_vec[0];
   assign debug_req_accept     = accept_vec[1];
   assign req_reject           = reject_vec;
   assign pending_auth_request = pending_reg;
   assign busy                 = (state_reg != ST_IDLE);
   assign timeout_err          = timeout_reg;

endmodule
